// File: rtl/uart_mem_pkg.sv
// uart_mem_pkg: command bytes, frame lengths and FSM states shared by initiator and responder
package uart_mem_pkg;
  localparam logic [7:0] CMD_WRITE = 8'h57;
  localparam logic [7:0] CMD_READ = 8'h52;
  localparam logic [7:0] ACK = 8'h06;
  localparam int WR_FRAME_LEN = 5;
  localparam int RD_FRAME_LEN = 3;
  typedef enum logic [2:0] {IDLE, SEND, TX_HOLD, TX_WAIT, RECV, DONE} state_e;
endpackage

// File: rtl/uart_mem_initiator_if.sv
// uart_mem_initiator_if: request/response bundle between user logic and the initiator
interface uart_mem_initiator_if #(parameter int MEM_SELECT_BITS = 4);
  logic req_valid;
  logic req_ready;
  logic req_write;
  logic [MEM_SELECT_BITS-1:0] req_sel;
  logic [7:0] req_addr;
  logic [15:0] req_wdata;
  logic rsp_valid;
  logic [15:0] rsp_rdata;
  logic rsp_error;
  modport master(output req_valid, req_write, req_sel, req_addr, req_wdata,
                 input req_ready, rsp_valid, rsp_rdata, rsp_error);
  modport slave(input req_valid, req_write, req_sel, req_addr, req_wdata,
                output req_ready, rsp_valid, rsp_rdata, rsp_error);
endinterface

// File: rtl/uart_timeout_ctr.sv
// uart_timeout_ctr: saturating inter-byte timeout counter with clear, enable and terminal count
module uart_timeout_ctr #(parameter int TIMEOUT_CYCLES = 480000) (
  input  logic clk,
  input  logic resetn,
  input  logic clr,
  input  logic en,
  output logic tc
);
  localparam int W = $clog2(TIMEOUT_CYCLES + 1);
  logic [W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = clr ? '0 : (en && cnt_q != W'(TIMEOUT_CYCLES)) ? cnt_q + 1'b1 : cnt_q;
  always_ff @(posedge clk) cnt_q <= !resetn ? '0 : cnt_d;
  assign tc = cnt_q == W'(TIMEOUT_CYCLES - 1);
endmodule

// File: rtl/uart_mem_initiator.sv
// uart_mem_initiator: serialises one read/write request into UART command bytes and collects the response
module uart_mem_initiator
  import uart_mem_pkg::*;
#(
  parameter int MEM_SELECT_BITS = 4,
  parameter int PAYLOAD_BITS = 8,
  parameter int TIMEOUT_CYCLES = 480000
) (
  input  logic clk,
  input  logic resetn,
  uart_mem_initiator_if.slave bus,
  output logic uart_tx_en,
  output logic [PAYLOAD_BITS-1:0] uart_tx_data,
  input  logic uart_tx_busy,
  input  logic uart_rx_valid,
  input  logic [PAYLOAD_BITS-1:0] uart_rx_data
);
  state_e state_q, state_d;
  logic [2:0] idx_q, idx_d, len_q, len_d;
  logic wr_q, wr_d, err_q, err_d, tx_en_q, tx_en_d;
  logic [PAYLOAD_BITS-1:0] frame_q [5];
  logic [PAYLOAD_BITS-1:0] frame_d [5];
  logic [PAYLOAD_BITS-1:0] tx_data_q, tx_data_d;
  logic [15:0] rdata_q, rdata_d;
  logic [MEM_SELECT_BITS-1:0] sel;
  logic last_tx, clr, en, tc;
  assign sel = bus.req_sel;
  assign last_tx = idx_q == len_q - 3'd1;
  assign clr = (state_q == TX_WAIT && !uart_tx_busy && last_tx) || (state_q == RECV && uart_rx_valid);
  assign en = state_q == RECV && !uart_rx_valid;
  uart_timeout_ctr #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
    .clk(clk), .resetn(resetn), .clr(clr), .en(en), .tc(tc)
  );
  always_comb begin
    state_d = state_q;
    idx_d = idx_q;
    len_d = len_q;
    wr_d = wr_q;
    err_d = err_q;
    frame_d = frame_q;
    rdata_d = rdata_q;
    tx_data_d = tx_data_q;
    tx_en_d = 1'b0;
    case (state_q)
      IDLE: if (bus.req_valid) begin
        state_d = SEND;
        idx_d = '0;
        wr_d = bus.req_write;
        len_d = bus.req_write ? 3'(WR_FRAME_LEN) : 3'(RD_FRAME_LEN);
        frame_d[0] = bus.req_write ? CMD_WRITE : CMD_READ;
        frame_d[1] = 8'(sel);
        frame_d[2] = bus.req_addr;
        frame_d[3] = bus.req_wdata[15:8];
        frame_d[4] = bus.req_wdata[7:0];
        rdata_d = '0;
        err_d = 1'b0;
      end
      SEND: if (!uart_tx_busy) begin
        tx_en_d = 1'b1;
        tx_data_d = frame_q[idx_q];
        state_d = TX_HOLD;
      end
      TX_HOLD: state_d = TX_WAIT;
      TX_WAIT: if (!uart_tx_busy) begin
        idx_d = last_tx ? 3'd0 : idx_q + 3'd1;
        state_d = last_tx ? RECV : SEND;
      end
      RECV: if (uart_rx_valid) begin
        if (wr_q) begin
          err_d = uart_rx_data != ACK;
          state_d = DONE;
        end else if (idx_q == 3'd0) begin
          rdata_d[15:8] = uart_rx_data;
          idx_d = 3'd1;
        end else begin
          rdata_d[7:0] = uart_rx_data;
          state_d = DONE;
        end
      end else if (tc) begin
        err_d = 1'b1;
        rdata_d = '0;
        state_d = DONE;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= IDLE;
      idx_q <= '0;
      len_q <= '0;
      wr_q <= 1'b0;
      err_q <= 1'b0;
      frame_q <= '{default: '0};
      rdata_q <= '0;
      tx_data_q <= '0;
      tx_en_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      len_q <= len_d;
      wr_q <= wr_d;
      err_q <= err_d;
      frame_q <= frame_d;
      rdata_q <= rdata_d;
      tx_data_q <= tx_data_d;
      tx_en_q <= tx_en_d;
    end
  end
  assign bus.req_ready = state_q == IDLE;
  assign bus.rsp_valid = state_q == DONE;
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_error = err_q;
  assign uart_tx_en = tx_en_q;
  assign uart_tx_data = tx_data_q;
endmodule

// File: tb/tb_uart_mem_initiator.sv
// tb_uart_mem_initiator: directed bench with a busy-timed uart_tx model and hand-driven rx bytes
module tb_uart_mem_initiator;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic uart_tx_en, uart_tx_busy, uart_rx_valid;
  logic [7:0] uart_tx_data, uart_rx_data;
  int checks = 0, failures = 0, cyc = 0, rsp_cnt = 0, busy_cnt = 0;
  int rx_edge, r_cyc, base, cnt0;
  logic r_err, r_ready;
  logic [15:0] r_data;
  logic [7:0] tx_q[$];
  uart_mem_initiator_if #(.MEM_SELECT_BITS(4)) bus ();
  uart_mem_initiator #(.MEM_SELECT_BITS(4), .PAYLOAD_BITS(8), .TIMEOUT_CYCLES(100)) u_dut (
    .clk(clk), .resetn(resetn), .bus(bus),
    .uart_tx_en(uart_tx_en), .uart_tx_data(uart_tx_data), .uart_tx_busy(uart_tx_busy),
    .uart_rx_valid(uart_rx_valid), .uart_rx_data(uart_rx_data)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) begin
    if (uart_tx_en) begin
      tx_q.push_back(uart_tx_data);
      busy_cnt <= 5;
    end else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
  end
  assign uart_tx_busy = busy_cnt != 0;
  always @(negedge clk) if (bus.rsp_valid) rsp_cnt <= rsp_cnt + 1;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic issue(input logic w, input logic [3:0] s, input logic [7:0] a, input logic [15:0] d);
    bus.req_valid = 1'b1;
    bus.req_write = w;
    bus.req_sel = s;
    bus.req_addr = a;
    bus.req_wdata = d;
    @(negedge clk);
    bus.req_valid = 1'b0;
  endtask
  task automatic rx_byte(input logic [7:0] b);
    uart_rx_valid = 1'b1;
    uart_rx_data = b;
    rx_edge = cyc + 1;
    @(negedge clk);
    uart_rx_valid = 1'b0;
  endtask
  task automatic wait_tx(input int n);
    for (int i = 0; i < 2000 && tx_q.size() < n; i++) @(negedge clk);
  endtask
  task automatic wait_frame(input int n);
    wait_tx(n);
    check("tx_byte_count", tx_q.size(), n);
    for (int i = 0; i < 200 && uart_tx_busy; i++) @(negedge clk);
    repeat (3) @(negedge clk);
  endtask
  task automatic check_frame(input string tag, input int b, input int n, input logic [39:0] exp);
    for (int i = 0; i < n; i++)
      check(tag, (b + i < tx_q.size()) ? 32'(tx_q[b + i]) : 32'hdead, 32'(exp[39 - 8 * i -: 8]));
  endtask
  task automatic wait_rsp(input int bound);
    for (int i = 0; i < bound && !bus.rsp_valid; i++) @(negedge clk);
    check("rsp_seen", bus.rsp_valid, 1);
    r_cyc = cyc;
    r_err = bus.rsp_error;
    r_data = bus.rsp_rdata;
    r_ready = bus.req_ready;
    @(negedge clk);
  endtask
  initial begin
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_sel = '0;
    bus.req_addr = '0;
    bus.req_wdata = '0;
    uart_rx_valid = 1'b0;
    uart_rx_data = '0;
    repeat (3) @(negedge clk);
    check("rst_req_ready", bus.req_ready, 1);
    check("rst_rsp_valid", bus.rsp_valid, 0);
    check("rst_rsp_error", bus.rsp_error, 0);
    check("rst_rsp_rdata", bus.rsp_rdata, 0);
    check("rst_tx_en", uart_tx_en, 0);
    check("rst_tx_data", uart_tx_data, 0);
    resetn = 1'b1;
    @(negedge clk);
    // write with good ack
    base = tx_q.size();
    issue(1'b1, 4'h3, 8'h1A, 16'hBEEF);
    check("wr_ready_drops", bus.req_ready, 0);
    wait_frame(base + 5);
    check_frame("wr_frame", base, 5, 40'h57031ABEEF);
    rx_byte(8'h06);
    wait_rsp(50);
    check("wr_err", r_err, 0);
    check("wr_rdata", r_data, 0);
    check("wr_rsp_latency", r_cyc - rx_edge, 0);
    // read
    base = tx_q.size();
    issue(1'b0, 4'hF, 8'hFF, 16'h0000);
    wait_frame(base + 3);
    check_frame("rd_frame", base, 3, 40'h520FFF0000);
    rx_byte(8'hAB);
    check("rd_no_early_rsp", bus.rsp_valid, 0);
    rx_byte(8'hCD);
    wait_rsp(50);
    check("rd_err", r_err, 0);
    check("rd_rdata", r_data, 16'hABCD);
    // write with bad ack
    base = tx_q.size();
    issue(1'b1, 4'h5, 8'h10, 16'h1234);
    wait_frame(base + 5);
    check_frame("bad_frame", base, 5, 40'h5705101234);
    rx_byte(8'h15);
    wait_rsp(50);
    check("bad_err", r_err, 1);
    check("bad_rdata", r_data, 0);
    check("bad_rsp_latency", r_cyc - rx_edge, 0);
    check("bad_ready_at_strobe", r_ready, 0);
    check("bad_ready_after", bus.req_ready, 1);
    check("bad_single_strobe", bus.rsp_valid, 0);
    // read with only one response byte -> timeout
    base = tx_q.size();
    issue(1'b0, 4'h1, 8'h20, 16'h0000);
    wait_frame(base + 3);
    rx_byte(8'h12);
    wait_rsp(300);
    check("to_err", r_err, 1);
    check("to_rdata", r_data, 0);
    check("to_latency", r_cyc - rx_edge, 100);
    // stray bytes in IDLE, SEND and TX_WAIT are ignored
    rx_byte(8'h06);
    @(negedge clk);
    check("stray_idle_ready", bus.req_ready, 1);
    cnt0 = rsp_cnt;
    base = tx_q.size();
    issue(1'b1, 4'h1, 8'h02, 16'h0304);
    rx_byte(8'h06);
    wait_tx(base + 1);
    rx_byte(8'h06);
    wait_frame(base + 5);
    check_frame("stray_frame", base, 5, 40'h5701020304);
    repeat (20) @(negedge clk);
    check("stray_no_rsp", rsp_cnt, cnt0);
    check("stray_busy", bus.req_ready, 0);
    rx_byte(8'h06);
    wait_rsp(50);
    check("stray_err", r_err, 0);
    // reset after two bytes of a write frame
    cnt0 = rsp_cnt;
    base = tx_q.size();
    issue(1'b1, 4'h7, 8'h33, 16'h5566);
    wait_tx(base + 2);
    check("mid_two_bytes", tx_q.size(), base + 2);
    resetn = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    check("mid_ready", bus.req_ready, 1);
    check("mid_tx_en", uart_tx_en, 0);
    repeat (20) @(negedge clk);
    check("mid_no_rsp", rsp_cnt, cnt0);
    check("mid_no_more_tx", tx_q.size(), base + 2);
    base = tx_q.size();
    issue(1'b0, 4'h2, 8'h44, 16'h0000);
    wait_frame(base + 3);
    check_frame("post_rst_frame", base, 3, 40'h5202440000);
    rx_byte(8'h12);
    rx_byte(8'h34);
    wait_rsp(50);
    check("post_rst_err", r_err, 0);
    check("post_rst_rdata", r_data, 16'h1234);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
